// File: rtl/lsu_stage_if.sv
// AXI4-Lite master bundle used by the load/store stage towards memory.
interface lsu_stage_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: one outstanding access at a time over AXI4-Lite, result
// registered towards commit. Non-memory ops pass the ALU result through.
module lsu_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_pre_i,
  output logic        ready_pre_o,
  output logic        valid_post_o,
  input  logic        ready_post_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] result_o,
  lsu_stage_if.master axi
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWrReq  = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign accept = valid_pre_i && (state_q == StIdle);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      funct3_q <= funct3_i;
      addr_q   <= addr_i;
      wdata_q  <= wdata_i;
    end
  end

  always_comb begin
    load_byte = axi.rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? axi.rdata[31:16] : axi.rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = axi.rdata;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000: begin
        axi.wstrb = 4'b0001 << addr_q[1:0];
        axi.wdata = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        axi.wstrb = 4'b0011 << {addr_q[1], 1'b0};
        axi.wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        axi.wstrb = 4'b1111;
        axi.wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // A request with both ren and wen set is treated as a load.
          if (mem_ren_i) begin
            state_d = StRdAddr;
          end else if (mem_wen_i) begin
            state_d   = StWrReq;
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
          end else begin
            state_d  = StDone;
            result_d = alu_result_i;
          end
        end
      end
      StRdAddr: if (axi.arready) state_d = StRdData;
      StRdData: begin
        if (axi.rvalid) begin
          result_d = load_data;
          state_d  = StDone;
        end
      end
      StWrReq: begin
        if (aw_pend_q && axi.awready) aw_pend_d = 1'b0;
        if (w_pend_q && axi.wready) w_pend_d = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = StWrResp;
      end
      StWrResp: begin
        if (axi.bvalid) begin
          result_d = '0;
          state_d  = StDone;
        end
      end
      StDone:   if (ready_post_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake outputs decode registered state only; reset forces the idle view.
  assign ready_pre_o  = reset || (state_q == StIdle);
  assign valid_post_o = !reset && (state_q == StDone);
  assign axi.arvalid  = !reset && (state_q == StRdAddr);
  assign axi.rready   = !reset && (state_q == StRdData);
  assign axi.awvalid  = !reset && (state_q == StWrReq) && aw_pend_q;
  assign axi.wvalid   = !reset && (state_q == StWrReq) && w_pend_q;
  assign axi.bready   = !reset && (state_q == StWrResp);
  assign axi.araddr   = addr_q;
  assign axi.awaddr   = addr_q;
  assign result_o     = reset ? 32'd0 : result_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage; results to commit are checked by a scoreboard monitor.
module tb_lsu_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        valid_pre_i;
  logic        ready_pre_o;
  logic        valid_post_o;
  logic        ready_post_i;
  logic        mem_ren_i;
  logic        mem_wen_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] alu_result_i;
  logic [31:0] result_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  lsu_stage_if axi ();

  lsu_stage dut (
    .clock        (clock),
    .reset        (reset),
    .valid_pre_i  (valid_pre_i),
    .ready_pre_o  (ready_pre_o),
    .valid_post_o (valid_post_o),
    .ready_post_i (ready_post_i),
    .mem_ren_i    (mem_ren_i),
    .mem_wen_i    (mem_wen_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .alu_result_i (alu_result_i),
    .result_o     (result_o),
    .axi          (axi)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every result handed to commit must match the queue head.
  always @(negedge clock) begin
    if (!reset && valid_post_o && ready_post_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL post_unexpected: got 0x%08h, expected no transfer", result_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("post_result", result_o, mon_exp);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu);
    int n;
    n = 0;
    while (!ready_pre_o && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!ready_pre_o) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got ready_pre_o=0, expected 1 within 50 cycles");
    end
    valid_pre_i  = 1'b1;
    mem_ren_i    = ren;
    mem_wen_i    = wen;
    funct3_i     = f3;
    addr_i       = a;
    wdata_i      = wd;
    alu_result_i = alu;
    @(posedge clock);
    #1;
    valid_pre_i  = 1'b0;
    mem_ren_i    = 1'($urandom);
    mem_wen_i    = 1'($urandom);
    funct3_i     = 3'($urandom);
    addr_i       = $urandom;
    wdata_i      = $urandom;
    alu_result_i = $urandom;
  endtask

  task automatic do_load(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input int ar_delay, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(1'b1, wen, f3, a, $urandom, $urandom);
    for (int c = 0; c <= ar_delay; c++) begin
      axi.arready = (c == ar_delay);
      @(negedge clock);
      check1("arvalid_high", axi.arvalid, 1'b1);
      check1("no_aw_on_load", axi.awvalid | axi.wvalid, 1'b0);
      if (c == 0) check("araddr", axi.araddr, a);
      @(posedge clock);
      #1;
    end
    axi.arready = 1'b0;
    @(negedge clock);
    check1("arvalid_dropped", axi.arvalid, 1'b0);
    check1("rready_high", axi.rready, 1'b1);
    axi.rvalid = 1'b1;
    axi.rdata  = rd;
    @(posedge clock);
    #1;
    axi.rvalid = 1'b0;
    axi.rdata  = $urandom;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input int aw_d, input int w_d, input logic [3:0] strb,
                          input logic [31:0] data);
    int n;
    n = (aw_d > w_d) ? aw_d : w_d;
    exp_q.push_back(32'd0);
    issue(1'b0, 1'b1, f3, a, wd, $urandom);
    for (int c = 0; c <= n; c++) begin
      axi.awready = (c == aw_d);
      axi.wready  = (c == w_d);
      @(negedge clock);
      check1("awvalid", axi.awvalid, c <= aw_d);
      check1("wvalid", axi.wvalid, c <= w_d);
      check1("bready_in_wr_req", axi.bready, 1'b0);
      if (c == 0) begin
        check("wstrb", {28'd0, axi.wstrb}, {28'd0, strb});
        check("wdata", axi.wdata, data);
        check("awaddr", axi.awaddr, a);
      end
      @(posedge clock);
      #1;
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    @(negedge clock);
    check1("aw_w_done", axi.awvalid | axi.wvalid, 1'b0);
    check1("bready_high", axi.bready, 1'b1);
    axi.bvalid = 1'b1;
    @(posedge clock);
    #1;
    axi.bvalid = 1'b0;
    @(negedge clock);
    check1("bready_single", axi.bready, 1'b0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected end within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    valid_pre_i  = 1'b0;
    ready_post_i = 1'b1;
    mem_ren_i    = 1'b0;
    mem_wen_i    = 1'b0;
    funct3_i     = 3'd0;
    addr_i       = '0;
    wdata_i      = '0;
    alu_result_i = '0;
    axi.arready  = 1'b0;
    axi.rvalid   = 1'b0;
    axi.rdata    = '0;
    axi.awready  = 1'b0;
    axi.wready   = 1'b0;
    axi.bvalid   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check1("rst_ready_pre", ready_pre_o, 1'b1);
    check1("rst_valid_post", valid_post_o, 1'b0);
    check1("rst_axi_valids", axi.arvalid | axi.awvalid | axi.wvalid, 1'b0);
    check1("rst_axi_readies", axi.rready | axi.bready, 1'b0);
    check("rst_result", result_o, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Non-memory op: one-cycle latency, one-cycle ready_post returns to idle.
    exp_q.push_back(32'h1234_5678);
    issue(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_5678);
    @(negedge clock);
    check1("alu_valid_post", valid_post_o, 1'b1);
    check1("alu_ready_pre_low", ready_pre_o, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check1("alu_back_idle", ready_pre_o, 1'b1);
    @(posedge clock);
    #1;

    do_load(1'b0, 3'b000, 32'h8000_0003, 32'h80FF_FF7F, 2, 32'hFFFF_FF80);
    do_load(1'b0, 3'b100, 32'h8000_0003, 32'h80FF_FF7F, 2, 32'h0000_0080);
    do_load(1'b0, 3'b001, 32'h8000_0000, 32'h1234_8001, 0, 32'hFFFF_8001);
    do_load(1'b0, 3'b101, 32'h8000_0002, 32'h1234_8001, 1, 32'h0000_1234);
    do_load(1'b0, 3'b000, 32'h0000_0001, 32'h0000_7F00, 0, 32'h0000_007F);
    do_load(1'b0, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    do_load(1'b0, 3'b011, 32'h0000_0013, 32'h89AB_CDEF, 0, 32'h89AB_CDEF);
    do_load(1'b1, 3'b010, 32'h0000_0100, 32'h55AA_55AA, 1, 32'h55AA_55AA);

    do_store(3'b001, 32'h8000_0002, 32'h0000_BEEF, 0, 2, 4'b1100, 32'hBEEF_BEEF);
    do_store(3'b000, 32'h0000_0001, 32'h1234_56A5, 0, 0, 4'b0010, 32'hA5A5_A5A5);
    do_store(3'b010, 32'h0000_0004, 32'h0102_0304, 3, 1, 4'b1111, 32'h0102_0304);
    do_store(3'b000, 32'h0000_0003, 32'h0000_0077, 1, 1, 4'b1000, 32'h7777_7777);
    do_store(3'b001, 32'h0000_0000, 32'hABCD_1234, 2, 0, 4'b0011, 32'h1234_1234);
    do_store(3'b011, 32'h0000_0002, 32'hCAFE_BABE, 0, 0, 4'b1111, 32'hCAFE_BABE);

    // Backpressure from commit: result and valid hold, no new accept.
    ready_post_i = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check1("bp_valid_post", valid_post_o, 1'b1);
      check("bp_result", result_o, 32'hCAFE_F00D);
      check1("bp_ready_pre", ready_pre_o, 1'b0);
      @(posedge clock);
      #1;
    end
    ready_post_i = 1'b1;
    @(posedge clock);
    #1;

    // Nonzero result beforehand so the reset clearing it is observable.
    do_load(1'b0, 3'b100, 32'h0000_0002, 32'h00AB_0000, 0, 32'h0000_00AB);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0);
    axi.arready = 1'b1;
    @(posedge clock);
    #1;
    axi.arready = 1'b0;
    @(negedge clock);
    check1("pre_rst_rready", axi.rready, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check1("in_rst_ready_pre", ready_pre_o, 1'b1);
    check1("in_rst_rready", axi.rready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check1("post_rst_arvalid", axi.arvalid, 1'b0);
    check1("post_rst_rready", axi.rready, 1'b0);
    check1("post_rst_valid_post", valid_post_o, 1'b0);
    check1("post_rst_ready_pre", ready_pre_o, 1'b1);
    check("post_rst_result", result_o, 32'd0);
    @(posedge clock);
    #1;

    exp_q.push_back(32'h0BAD_F00D);
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0BAD_F00D);
    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed (32-bit data/address, 4-bit strobe).
REQ-002 clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_pre_i / ready_pre_o  in/out  1/1  handshake from the execute stage.
REQ-005 valid_post_o / ready_post_i  out/in  1/1  handshake to the commit stage.
REQ-006 mem_ren_i, mem_wen_i  input  1 each  load / store request.
REQ-007 funct3_i  input  3  access size and sign (RV32I load/store encoding).
REQ-008 addr_i, wdata_i, alu_result_i  input  32 each  effective address, store data, non-memory result.
REQ-009 result_o  output  32  registered result presented to commit.
REQ-010 araddr_o 32 out, arvalid_o 1 out, arready_i 1 in: AXI4-Lite read address channel.
REQ-011 rdata_i 32 in, rvalid_i 1 in, rready_o 1 out: AXI4-Lite read data channel.
REQ-012 awaddr_o 32 out, awvalid_o 1 out, awready_i 1 in: AXI4-Lite write address channel.
REQ-013 wdata_o 32 out, wstrb_o 4 out, wvalid_o 1 out, wready_i 1 in: AXI4-Lite write data channel.
REQ-014 bvalid_i 1 in, bready_o 1 out: AXI4-Lite write response channel; response code SHALL be ignored.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP and DONE.
REQ-016 ready_pre_o SHALL be 1 only in IDLE; accept = valid_pre_i && ready_pre_o.
REQ-017 On accept, the block SHALL latch mem_ren_i, mem_wen_i, funct3_i, addr_i, wdata_i and alu_result_i; inputs SHALL be ignored outside accept.
REQ-018 IDLE transitions on accept SHALL be: ren -> RD_ADDR; else wen -> WR_REQ; else -> DONE with result_o = alu_result_i (1-cycle latency).
REQ-019 Both ren and wen set SHALL be handled as a load; no write SHALL be issued.
REQ-020 RD_ADDR: arvalid_o = 1 and araddr_o = latched address (unmodified); on arready_i the FSM SHALL move to RD_DATA.
REQ-021 RD_DATA: rready_o = 1; on rvalid_i the block SHALL write the formatted load into result_o and move to DONE.
REQ-022 Load format: LB/LBU (000/100) SHALL select byte addr[1:0], LH/LHU (001/101) SHALL select halfword addr[1], and LW (010) SHALL take the full word; 000/001 sign-extend and 100/101 zero-extend.
REQ-023 WR_REQ: awvalid_o and wvalid_o SHALL assert together on entry, and each SHALL drop in the cycle after its own handshake.
REQ-024 WR_REQ SHALL exit to WR_RESP when both AW and W have completed, including when both complete in the same cycle or in different cycles.
REQ-025 Store format: SB SHALL drive wstrb = 4'b0001<<addr[1:0] with the byte replicated on all lanes; SH SHALL drive wstrb = 4'b0011<<{addr[1],1'b0} with the halfword replicated; SW SHALL drive wstrb = 4'b1111 with data unchanged.
REQ-026 WR_RESP: bready_o = 1; on bvalid_i result_o SHALL become 0 and the FSM SHALL move to DONE.
REQ-027 DONE: valid_post_o = 1 and result_o SHALL be stable; on ready_post_i the FSM SHALL return to IDLE.
REQ-028 All AXI valid/ready outputs SHALL be driven from state registers only, with no combinational path from any AXI input.
REQ-029 Misaligned addresses SHALL NOT be detected; lane selection SHALL use only the bits named in REQ-022/REQ-025.
REQ-030 Undefined funct3 codes SHALL be treated as word access.

Reset
REQ-031 While reset = 1 the state SHALL be IDLE and result_o = 0.
REQ-032 While reset = 1, ready_pre_o = 1 and every other handshake output SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the access, with all valids low from the next cycle.

Verification
REQ-034 ALU op: accept with alu_result_i = 0x1234_5678, ren = wen = 0 -> valid_post_o = 1 next cycle, result_o = 0x1234_5678; one-cycle ready_post_i -> IDLE.
REQ-035 LB sign: addr 0x8000_0003, rdata 0x80FF_FF7F, arready after 2 cycles -> result_o = 0xFFFF_FF80; LBU with the same stimulus -> 0x0000_0080.
REQ-036 SH upper: addr 0x8000_0002, wdata 0x0000_BEEF -> wstrb = 4'b1100, wdata_o = 0xBEEF_BEEF; awready two cycles before wready -> single WR_RESP entry; bvalid -> result_o = 0.
REQ-037 Simultaneous AW/W: awready = wready = 1 in the first cycle -> both valids low the next cycle, FSM in WR_RESP.
REQ-038 Backpressure: ready_post_i low for 5 cycles in DONE -> result_o and valid_post_o hold, ready_pre_o stays 0.
REQ-039 Reset in RD_DATA: reset for 1 cycle -> arvalid_o/rready_o/valid_post_o = 0, ready_pre_o = 1, result_o = 0.
